// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-merge stage between the execution units and the
// single register-file write port.
//
// Each of three sources (ALU=0, LSU=1, CSR=2) pushes {data, adr} through a
// valid/ready channel into its own DEPTH-entry FIFO. A round-robin arbiter
// drains the FIFO heads into one registered writeback port, one write per
// cycle. Writes to x0 complete the handshake but are never enqueued.
//
// Parameters:
//   XLEN   data width
//   DEPTH  entries per source FIFO (power of two, >= 2)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   {alu,lsu,csr}_valid/ready   per-source handshake (ready = FIFO not full)
//   {alu,lsu,csr}_data/adr      per-source writeback payload
//   wb_valid/wb_data/wb_adr     registered register-file write port
//   pending_mask                only when WB_ARB_PENDING_EN is defined:
//                               bit r set iff a queued entry or the live
//                               output targets register r (bit 0 always 0)
//
// Optional feature macro: WB_ARB_PENDING_EN

// Per-source FIFO lane. Separate count register keeps full/empty unambiguous.
module wb_arb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
`ifdef WB_ARB_PENDING_EN
  ,
  output logic [31:0]  mask_o
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           rd_q, wr_q;
  logic [AW:0]             cnt_q, cnt_d;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign cnt_d   = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: only entries below cnt_q are ever observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

`ifdef WB_ARB_PENDING_EN
  always_comb begin
    mask_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < cnt_q) mask_o[mem_q[rd_q + AW'(k)][4:0]] = 1'b1;
    end
  end
`endif
endmodule

module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [XLEN-1:0] alu_data,
  input  logic [4:0]      alu_adr,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [4:0]      lsu_adr,
  input  logic            csr_valid,
  output logic            csr_ready,
  input  logic [XLEN-1:0] csr_data,
  input  logic [4:0]      csr_adr,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_adr
`ifdef WB_ARB_PENDING_EN
  ,
  output logic [31:0]     pending_mask
`endif
);
  localparam int NSRC = 3;
  localparam int W    = XLEN + 5;

  logic [NSRC-1:0]        vld, nz, full, empty, push, pop;
  logic [NSRC-1:0][W-1:0] in_ent, head;
  logic [1:0]             rr_q, gnt_idx, c0, c1, c2;
  logic                   any;
  logic                   wb_valid_q;
  logic [XLEN-1:0]        wb_data_q;
  logic [4:0]             wb_adr_q;

  assign vld       = {csr_valid, lsu_valid, alu_valid};
  assign nz        = {|csr_adr, |lsu_adr, |alu_adr};
  assign in_ent[0] = {alu_data, alu_adr};
  assign in_ent[1] = {lsu_data, lsu_adr};
  assign in_ent[2] = {csr_data, csr_adr};

  // Ready depends only on registered occupancy: no valid->ready path, and a
  // full FIFO stalls even if it is popped this cycle.
  assign alu_ready = ~full[0];
  assign lsu_ready = ~full[1];
  assign csr_ready = ~full[2];
  // x0 writes handshake normally but are dropped here.
  assign push = vld & ~full & nz;

`ifdef WB_ARB_PENDING_EN
  logic [NSRC-1:0][31:0] fmask;
`endif

  wb_arb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo [NSRC-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (in_ent),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
`ifdef WB_ARB_PENDING_EN
    ,
    .mask_o  (fmask)
`endif
  );

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search begins one past the last grant; first non-empty head wins.
  assign c0  = nxt(rr_q);
  assign c1  = nxt(c0);
  assign c2  = nxt(c1);
  assign any = ~&empty;

  always_comb begin
    gnt_idx = rr_q;
    if      (!empty[c0]) gnt_idx = c0;
    else if (!empty[c1]) gnt_idx = c1;
    else if (!empty[c2]) gnt_idx = c2;
  end

  always_comb begin
    pop = '0;
    if (any) pop[gnt_idx] = 1'b1;
  end

  // rr resets to CSR so ALU has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 2'd2;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_adr_q   <= '0;
    end else begin
      wb_valid_q <= any;
      if (any) begin
        rr_q      <= gnt_idx;
        wb_data_q <= head[gnt_idx][W-1:5];
        wb_adr_q  <= head[gnt_idx][4:0];
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_adr   = wb_adr_q;

`ifdef WB_ARB_PENDING_EN
  always_comb begin
    pending_mask = fmask[0] | fmask[1] | fmask[2];
    if (wb_valid_q) pending_mask[wb_adr_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  logic        clk, rst_n;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready, csr_valid, csr_ready;
  logic [31:0] alu_data, lsu_data, csr_data, wb_data;
  logic [4:0]  alu_adr, lsu_adr, csr_adr, wb_adr;
  logic        wb_valid;
`ifdef WB_ARB_PENDING_EN
  logic [31:0] pending_mask;
`endif
  int checks = 0, failures = 0;

  wb_arbiter #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_adr(alu_adr),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_data(lsu_data), .lsu_adr(lsu_adr),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_data(csr_data), .csr_adr(csr_adr),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_adr(wb_adr)
`ifdef WB_ARB_PENDING_EN
    , .pending_mask(pending_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; csr_valid = 0;
    alu_adr = 0; lsu_adr = 0; csr_adr = 0;
    alu_data = 0; lsu_data = 0; csr_data = 0;
  endtask

  // Leaves the bench 1ns after the first edge following reset release.
  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    step();
  endtask

  initial begin
    do_reset();
    // Reset state
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data",  wb_data, 0);
    chk("rst_wb_adr",   wb_adr, 0);
    chk("rst_readys",   {alu_ready, lsu_ready, csr_ready}, 3'b111);
`ifdef WB_ARB_PENDING_EN
    chk("rst_mask", pending_mask, 0);
`endif

    // Single ALU write: handshake cycle 1, wb_valid in cycle 3
    alu_valid = 1; alu_adr = 5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    chk("single_c2_valid", wb_valid, 0);
    step();
    chk("single_c3_valid", wb_valid, 1);
    chk("single_c3_adr",   wb_adr, 5);
    chk("single_c3_data",  wb_data, 32'hDEADBEEF);
    step();
    chk("single_c4_valid", wb_valid, 0);
    chk("single_hold_data", wb_data, 32'hDEADBEEF);
    chk("single_hold_adr",  wb_adr, 5);

    // x0 drop
    lsu_valid = 1; lsu_adr = 0; lsu_data = 32'h1234;
    chk("x0_ready_pre", lsu_ready, 1);
    step();
    idle();
    chk("x0_ready_post", lsu_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("x0_no_wb", wb_valid, 0);
      step();
    end

    // Round-robin fairness: ALU 1,2 / LSU 3,4 / CSR 5,6
    do_reset();
    alu_valid = 1; lsu_valid = 1; csr_valid = 1;
    alu_adr = 1; lsu_adr = 3; csr_adr = 5;
    alu_data = 32'h11; lsu_data = 32'h33; csr_data = 32'h55;
    step();
    alu_adr = 2; lsu_adr = 4; csr_adr = 6;
    alu_data = 32'h22; lsu_data = 32'h44; csr_data = 32'h66;
    chk("rr_readys", {alu_ready, lsu_ready, csr_ready}, 3'b111);
    step();
    idle();
    begin
      logic [4:0] exp_adr [6];
      exp_adr = '{5'd1, 5'd3, 5'd5, 5'd2, 5'd4, 5'd6};
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("rr_valid_%0d", i), wb_valid, 1);
        chk($sformatf("rr_adr_%0d", i), wb_adr, exp_adr[i]);
        chk($sformatf("rr_data_%0d", i), wb_data, 32'(exp_adr[i]) * 32'h11);
        step();
      end
    end
    chk("rr_done", wb_valid, 0);

    // Backpressure: ALU/LSU held valid, CSR pushes 20,21,22
    do_reset();
    alu_valid = 1; alu_adr = 1; alu_data = 32'hA;
    lsu_valid = 1; lsu_adr = 2; lsu_data = 32'hB;
    csr_valid = 1; csr_adr = 20; csr_data = 32'hC0;
    chk("bp_c0_ready", csr_ready, 1);
    step();
    csr_adr = 21; csr_data = 32'hC1;
    chk("bp_c1_ready", csr_ready, 1);
    step();
    csr_adr = 22; csr_data = 32'hC2;
    chk("bp_c2_ready", csr_ready, 0);
    chk("bp_e2_adr", wb_adr, 1);
    step();
    chk("bp_c3_ready", csr_ready, 0);
    chk("bp_e3_adr", wb_adr, 2);
    step();
    chk("bp_c4_ready", csr_ready, 1);
    chk("bp_e4_adr",  wb_adr, 20);
    chk("bp_e4_data", wb_data, 32'hC0);
    step();
    csr_valid = 0; csr_adr = 0;
    chk("bp_e5_adr", wb_adr, 1);
    step(); step();
    chk("bp_e7_adr",  wb_adr, 21);
    chk("bp_e7_data", wb_data, 32'hC1);
    step(); step(); step();
    chk("bp_e10_valid", wb_valid, 1);
    chk("bp_e10_adr",   wb_adr, 22);
    chk("bp_e10_data",  wb_data, 32'hC2);

    // Async reset mid-cycle with queued ALU/LSU entries
    idle();
    #2 rst_n = 0;
    #1;
    chk("ar_valid_now", wb_valid, 0);
    chk("ar_adr_now",   wb_adr, 0);
    chk("ar_readys_now", {alu_ready, lsu_ready, csr_ready}, 3'b111);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ar_no_stale_%0d", i), wb_valid, 0);
      chk($sformatf("ar_readys_%0d", i), {alu_ready, lsu_ready, csr_ready}, 3'b111);
    end

`ifdef WB_ARB_PENDING_EN
    do_reset();
    alu_valid = 1; alu_adr = 7; alu_data = 32'h7;
    lsu_valid = 1; lsu_adr = 9; lsu_data = 32'h9;
    step();
    idle();
    chk("pm_queued", pending_mask, 32'h0000_0280);
    step();
    chk("pm_alu_on_wb", pending_mask, 32'h0000_0280);
    chk("pm_alu_adr", wb_adr, 7);
    step();
    chk("pm_alu_clear", pending_mask, 32'h0000_0200);
    chk("pm_lsu_adr", wb_adr, 9);
    step();
    chk("pm_empty", pending_mask, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
